ibus_line_bridge: RTL and testbench

IBUS_LINE_BRIDGE -- requirements
Module: ibus_line_bridge

---
 rtl/ibus_line_bridge.sv | 148 ++++++++++++++
 tb/tb_ibus_line_bridge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_line_bridge.sv
// ibus_line_bridge: single-line instruction fetch buffer that refills whole lines over cbus INCR bursts.
module ibus_line_bridge #(
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned OFFSET_W   = $clog2(LINE_BEATS) + 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [63:0] iresp_data,
  input  logic        invalidate,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [2:0]  creq_size,
  output logic [63:0] creq_addr,
  output logic [7:0]  creq_len,
  output logic [1:0]  creq_burst,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [63:0] cresp_data
);

  localparam int unsigned BEAT_W = $clog2(LINE_BEATS);
  localparam int unsigned TAG_W  = 64 - OFFSET_W;
  localparam int unsigned IDX_W  = OFFSET_W - 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [TAG_W-1:0]    req_line_q, req_line_d;
  logic                line_valid_q, line_valid_d;
  logic                inval_seen_q, inval_seen_d;
  logic                drain_q, drain_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [63:0]         data_q [LINE_BEATS];
  logic [63:0]         data_d [LINE_BEATS];

  logic                hit;
  logic                busy;
  logic                beat;
  logic                beat_last;
  logic                launch;
  logic [IDX_W-1:0]    hit_idx;
  logic                unused_addr_bits;

  assign hit_idx          = ireq_addr[OFFSET_W-1:3];
  assign unused_addr_bits = ^ireq_addr[2:0];
  assign busy             = (state_q != S_IDLE);
  assign beat             = busy & cresp_ready;
  assign beat_last        = beat & cresp_last;
  assign hit              = ireq_valid & line_valid_q & (tag_q == ireq_addr[63:OFFSET_W]) & ~busy;
  // Beats seen while idle belong to a burst orphaned by reset; no new request goes out until it ends.
  assign launch           = ~busy & ireq_valid & ~hit & ~drain_q & ~(cresp_ready & ~cresp_last);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a refill always runs until its last beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (launch) state_d = S_REQ;
      S_REQ:   if (cresp_ready) state_d = cresp_last ? S_IDLE : S_FILL;
      S_FILL:  if (cresp_ready && cresp_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: hit response is combinational, request valid follows the REQ state
  always_comb begin
    creq_valid    = (state_q == S_REQ);
    iresp_addr_ok = hit;
    iresp_data_ok = hit;
    iresp_data    = hit ? data_q[hit_idx] : 64'd0;
  end

  assign creq_is_write = 1'b0;
  assign creq_size     = 3'd3;
  assign creq_addr     = {req_line_q, {OFFSET_W{1'b0}}};
  assign creq_len      = 8'(LINE_BEATS - 1);
  assign creq_burst    = 2'b01;

  // Line bookkeeping: tag, validity, beat counter, invalidate tracking and stale-burst drain
  always_comb begin
    tag_d        = tag_q;
    req_line_d   = req_line_q;
    line_valid_d = line_valid_q;
    inval_seen_d = inval_seen_q;
    drain_d      = drain_q;
    beat_cnt_d   = beat_cnt_q;
    if (launch) begin
      req_line_d   = ireq_addr[63:OFFSET_W];
      line_valid_d = 1'b0;
      inval_seen_d = 1'b0;
    end else if (!busy && invalidate) begin
      line_valid_d = 1'b0;
    end
    if (busy && invalidate) inval_seen_d = 1'b1;
    if (beat) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    if (beat_last) begin
      tag_d        = req_line_q;
      line_valid_d = ~(inval_seen_q | invalidate);
      beat_cnt_d   = '0;
    end
    if (!busy && cresp_ready) drain_d = ~cresp_last;
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q        <= '0;
      req_line_q   <= '0;
      line_valid_q <= 1'b0;
      inval_seen_q <= 1'b0;
      drain_q      <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      tag_q        <= tag_d;
      req_line_q   <= req_line_d;
      line_valid_q <= line_valid_d;
      inval_seen_q <= inval_seen_d;
      drain_q      <= drain_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Line data write port: one word per accepted beat
  always_comb begin
    data_d = data_q;
    if (beat) data_d[beat_cnt_q] = cresp_data;
  end

  // Line data storage, left unreset
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // A burst must deliver exactly LINE_BEATS beats; an early last leaves stale words in the line
  a_full_burst: assert property (@(posedge clk) disable iff (!reset)
    beat_last |-> (beat_cnt_q == BEAT_W'(LINE_BEATS - 1)));

endmodule

// File: tb/tb_ibus_line_bridge.sv
// tb_ibus_line_bridge: directed scenarios, a hit table and a randomized run against a line-buffer model.
module tb_ibus_line_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = 64'd0;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [63:0] iresp_data;
  logic        invalidate = 1'b0;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_len;
  logic [1:0]  creq_burst;
  logic        cresp_ready = 1'b0;
  logic        cresp_last = 1'b0;
  logic [63:0] cresp_data = 64'd0;

  ibus_line_bridge dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .invalidate(invalidate),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_len(creq_len), .creq_burst(creq_burst),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- cbus memory slave ----------------
  bit          sl_active = 0;
  bit          sl_last_sent = 0;
  bit          sl_gap_done = 0;
  int          sl_cnt = 0;
  int          sl_gap_at = -1;
  int          sl_gap_pct = 0;
  int          sl_mode = 0;
  int          sl_last_cyc = -100;
  int          sl_creq_gap = 0;
  logic [31:0] sl_epoch = 32'd0;
  logic [63:0] sl_addr = 64'd0;
  logic [7:0]  sl_len = 8'd0;
  logic [63:0] creq_q [$];

  // Answers each request with 8 beats; keeps going across a DUT reset like a real fabric would
  always begin
    @(posedge clk); #1;
    if (sl_last_sent) begin sl_active = 0; sl_last_sent = 0; end
    if (!sl_active && reset && creq_valid) begin
      sl_active   = 1;
      sl_cnt      = 0;
      sl_gap_done = 0;
      sl_addr     = creq_addr;
      sl_len      = creq_len;
      sl_creq_gap = cyc - sl_last_cyc;
      sl_epoch    = sl_epoch + 32'd1;
      creq_q.push_back(creq_addr);
    end
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = {$urandom, $urandom};
    if (sl_active && !sl_last_sent) begin
      if (sl_cnt == sl_gap_at && !sl_gap_done) begin
        sl_gap_done = 1;
      end else if ($urandom_range(0, 99) >= sl_gap_pct) begin
        cresp_ready = 1'b1;
        cresp_data  = (sl_mode == 0) ? 64'h1000 + 64'(sl_cnt)
                                     : {sl_epoch, sl_addr[31:0]} + 64'(sl_cnt * 3);
        cresp_last  = (sl_cnt == 7);
        if (sl_cnt == 7) begin sl_last_sent = 1; sl_last_cyc = cyc; end
        sl_cnt++;
      end
    end
  end

  // ---------------- reference model: one cached line ----------------
  bit          m_busy = 0, m_req = 0, m_valid = 0, m_inv = 0, exp_hit;
  logic [57:0] m_tag = '0, m_pend = '0;
  int          m_cnt = 0;
  logic [63:0] m_data [8];
  logic [13:0] req_attr;

  always @(negedge clk) begin
    if (!reset) begin
      m_busy = 0; m_req = 0; m_valid = 0; m_inv = 0; m_cnt = 0; m_tag = '0;
      chk("reset_creq_valid", 64'(creq_valid), 64'd0);
      chk("reset_data_ok", 64'({iresp_addr_ok, iresp_data_ok}), 64'd0);
      chk("reset_iresp_data", iresp_data, 64'd0);
    end else begin
      exp_hit = !m_busy && m_valid && ireq_valid && (ireq_addr[63:6] == m_tag);
      chk("hit_addr_ok", 64'(iresp_addr_ok), 64'(exp_hit));
      chk("hit_data_ok", 64'(iresp_data_ok), 64'(exp_hit));
      chk("hit_data", iresp_data, exp_hit ? m_data[ireq_addr[5:3]] : 64'd0);
      chk("creq_valid", 64'(creq_valid), 64'(m_req));
      if (m_req) begin
        chk("creq_addr", creq_addr, {m_pend, 6'd0});
        req_attr = {creq_is_write, creq_size, creq_len, creq_burst};
        chk("creq_attr", 64'(req_attr), 64'({1'b0, 3'd3, 8'd7, 2'b01}));
      end
      if (!m_busy) begin
        if (invalidate) m_valid = 0;
        if (ireq_valid && !exp_hit) begin
          m_busy = 1; m_req = 1; m_valid = 0; m_inv = 0; m_cnt = 0;
          m_pend = ireq_addr[63:6];
        end
      end else begin
        if (invalidate) m_inv = 1;
        if (cresp_ready) begin
          m_req = 0;
          m_data[m_cnt] = cresp_data;
          m_cnt = (m_cnt + 1) % 8;
          if (cresp_last) begin
            m_busy = 0; m_cnt = 0;
            m_tag = m_pend;
            m_valid = !(m_inv || invalidate);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_data_ok(input string nm, input int max);
    bit got = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (reset && iresp_data_ok) begin got = 1; break; end
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  task automatic wait_beats(input string nm, input int n);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sl_active && sl_cnt >= n) begin got = 1; break; end
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  typedef struct {
    logic        valid;
    logic [63:0] addr;
    logic        inval;
    logic        exp_ok;
    logic [63:0] exp_data;
  } vec_t;
  vec_t tbl [7];

  int stale_ok;
  bit stale_done;

  initial begin
    tbl[0] = '{1'b1, 64'h8000_0000, 1'b0, 1'b1, 64'h1000};
    tbl[1] = '{1'b1, 64'h8000_0038, 1'b0, 1'b1, 64'h1007};
    tbl[2] = '{1'b0, 64'h8000_0038, 1'b0, 1'b0, 64'h0};
    tbl[3] = '{1'b1, 64'h8000_0018, 1'b0, 1'b1, 64'h1003};
    tbl[4] = '{1'b1, 64'h8000_0028, 1'b1, 1'b1, 64'h1005};
    tbl[5] = '{1'b0, 64'h8000_0028, 1'b0, 1'b0, 64'h0};
    tbl[6] = '{1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'h0};

    // Reset state with a request already pending
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0010;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_no_resp", 64'(iresp_data_ok), 64'd0);
    chk("rst_no_creq", 64'(creq_valid), 64'd0);
    tick();
    ireq_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Cold miss with one idle gap before beat 4
    sl_mode = 0; sl_gap_pct = 0; sl_gap_at = 4;
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0010;
    wait_data_ok("cold_data_ok", 100);
    chk("cold_data", iresp_data, 64'h1002);
    chk("cold_latency", 64'(cyc), 64'(sl_last_cyc + 1));
    chk("cold_creq_count", 64'(creq_q.size()), 64'd1);
    chk("cold_creq_addr", creq_q[0], 64'h8000_0000);
    chk("cold_creq_len", 64'(sl_len), 64'd7);
    sl_gap_at = -1;

    // Hit streak, idle cycles and invalidate-in-idle from the table
    for (int i = 0; i < 7; i++) begin
      tick();
      ireq_valid = tbl[i].valid;
      ireq_addr  = tbl[i].addr;
      invalidate = tbl[i].inval;
      @(negedge clk);
      chk($sformatf("tbl%0d_ok", i), 64'(iresp_data_ok), 64'(tbl[i].exp_ok));
      chk($sformatf("tbl%0d_data", i), iresp_data, tbl[i].exp_data);
    end
    chk("tbl_no_creq", 64'(creq_q.size()), 64'd1);

    // Redirect at beat 3: refill completes, then a new request for the new line
    wait_beats("redirect_beat3", 3);
    tick();
    ireq_addr = 64'h8000_1000;
    wait_data_ok("redirect_data_ok", 300);
    chk("redirect_data", iresp_data, 64'h1000);
    chk("redirect_creq_count", 64'(creq_q.size()), 64'd3);
    chk("redirect_first", creq_q[1], 64'h8000_0000);
    chk("redirect_second", creq_q[2], 64'h8000_1000);
    chk("b2b_creq_within_2", 64'(sl_creq_gap <= 2), 64'd1);

    // Invalidate at beat 5 of a fill: same address misses again
    tick();
    ireq_addr = 64'h8000_0048;
    wait_beats("inval_beat5", 5);
    tick();
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    wait_data_ok("inval_data_ok", 300);
    chk("inval_data", iresp_data, 64'h1001);
    chk("inval_creq_count", 64'(creq_q.size()), 64'd5);
    chk("inval_refill_addr", creq_q[4], 64'h8000_0040);

    // Reset at beat 4: stale beats ignored, next miss behaves normally
    tick();
    ireq_addr = 64'h8000_2008;
    wait_beats("rst_beat4", 4);
    tick();
    reset = 1'b0;
    ireq_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    stale_ok = 0;
    stale_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (iresp_data_ok) stale_ok++;
      if (!sl_active) begin stale_done = 1; break; end
    end
    chk("stale_burst_done", 64'(stale_done), 64'd1);
    chk("stale_no_data_ok", 64'(stale_ok), 64'd0);
    repeat (3) tick();
    chk("stale_no_creq", 64'(creq_q.size()), 64'd6);
    ireq_valid = 1'b1;
    wait_data_ok("post_rst_data_ok", 300);
    chk("post_rst_data", iresp_data, 64'h1001);
    chk("post_rst_creq_count", 64'(creq_q.size()), 64'd7);
    chk("post_rst_creq_addr", creq_q[6], 64'h8000_2000);

    // Randomized traffic checked cycle by cycle by the model
    sl_mode = 1; sl_gap_pct = 30;
    for (int i = 0; i < 2000; i++) begin
      tick();
      ireq_valid = ($urandom_range(0, 99) < 70);
      ireq_addr  = 64'h8000_0000 + 64'($urandom_range(0, 2)) * 64 + 64'($urandom_range(0, 7)) * 8;
      invalidate = ($urandom_range(0, 99) < 3);
    end
    tick();
    ireq_valid = 1'b0;
    invalidate = 1'b0;
    stale_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!sl_active && !creq_valid) begin stale_done = 1; break; end
    end
    chk("random_drain", 64'(stale_done), 64'd1);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
